// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM encoding, branch condition
// codes and datapath Status flag bit positions.
package pc_fetch_ctrl_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } fetch_state_t;

   localparam logic [2:0] BR_ALWAYS = 3'b000;
   localparam logic [2:0] BR_Z      = 3'b001;
   localparam logic [2:0] BR_NZ     = 3'b010;
   localparam logic [2:0] BR_N      = 3'b011;
   localparam logic [2:0] BR_NN     = 3'b100;
   localparam logic [2:0] BR_C      = 3'b101;
   localparam logic [2:0] BR_V      = 3'b110;
   localparam logic [2:0] BR_NEVER  = 3'b111;

   localparam int ST_V = 3;
   localparam int ST_C = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Execute-stage handshake between the datapath (master) and the fetch
// controller (slave): branch target/flags/completion in, IR/PC out.
interface pc_fetch_ctrl_if;
   logic [31:0] PC_in;
   logic [3:0]  Status;
   logic        PC_LOAD;
   logic [2:0]  BR_COND;
   logic        EX_DONE;
   logic        STALL;
   logic [31:0] IR;
   logic        IR_VALID;
   logic [31:0] PC;

   modport master (
      output PC_in, Status, PC_LOAD, BR_COND, EX_DONE, STALL,
      input  IR, IR_VALID, PC
   );

   modport slave (
      input  PC_in, Status, PC_LOAD, BR_COND, EX_DONE, STALL,
      output IR, IR_VALID, PC
   );
endinterface

// File: rtl/pc_fetch_ctrl_branch_cond_eval.sv
// Combinational branch condition evaluator: BR_COND code against {V,C,N,Z}.
module branch_cond_eval
   import pc_fetch_ctrl_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic [3:0] status,
   output logic       cond_ok
);

   always_comb begin
      cond_ok = 1'b0;
      case (br_cond)
         BR_ALWAYS: cond_ok = 1'b1;
         BR_Z:      cond_ok = status[ST_Z];
         BR_NZ:     cond_ok = ~status[ST_Z];
         BR_N:      cond_ok = status[ST_N];
         BR_NN:     cond_ok = ~status[ST_N];
         BR_C:      cond_ok = status[ST_C];
         BR_V:      cond_ok = status[ST_V];
         BR_NEVER:  cond_ok = 1'b0;
         default:   cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: two-state fetch/execute sequencer with PC update.
// Define BRANCH_COND_EN to qualify PC_LOAD with the BR_COND/Status condition.
//
// state | meaning
// FETCH | ADDR=PC, OE=1; latch D[31:0] into IR unless STALL
// EXEC  | bus released; hold IR until EX_DONE, then update PC
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [63:0]        D,
   output logic [31:0]        ADDR,
   output logic               OE,
   pc_fetch_ctrl_if.slave     ex
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic         ir_valid_q, ir_valid_d;
   logic         taken;

`ifdef BRANCH_COND_EN
   logic cond_ok;
   logic unused_bus;

   branch_cond_eval u_cond (
      .br_cond (ex.BR_COND),
      .status  (ex.Status),
      .cond_ok (cond_ok)
   );

   assign taken      = ex.PC_LOAD & cond_ok;
   assign unused_bus = ^D[63:32];
`else
   logic unused_bus;

   assign taken      = ex.PC_LOAD;
   assign unused_bus = ^{D[63:32], ex.BR_COND, ex.Status};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_VECTOR;
         ir_q       <= 32'h0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      case (state_q)
         FETCH: begin
            if (!ex.STALL) begin
               ir_d       = D[31:0];
               ir_valid_d = 1'b1;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (ex.EX_DONE) begin
               pc_d       = taken ? ex.PC_in : pc_q + STEP;
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset gates the bus combinationally so it is released without a clock.
   assign OE          = (state_q == FETCH) & rst;
   assign ADDR        = OE ? pc_q : 'z;
   assign ex.IR       = ir_q;
   assign ex.IR_VALID = ir_valid_q;
   assign ex.PC       = pc_q;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 D  input  64  shared data bus; instruction taken from D[31:0].
REQ-006 PC_in  input  32  branch/jump target from the datapath PC mux.
REQ-007 Status  input  4  datapath flags {V,C,N,Z}.
REQ-008 PC_LOAD  input  1  execute stage requests PC <= PC_in.
REQ-009 BR_COND  input  3  branch condition code.
REQ-010 EX_DONE  input  1  execute stage finished the current instruction (1-cycle pulse).
REQ-011 STALL  input  1  hold fetch (bus busy).
REQ-012 ADDR  output  32  address bus; PC while in FETCH, high-Z otherwise.
REQ-013 OE  output  1  memory output enable; 1 only in FETCH.
REQ-014 IR  output  32  instruction register.
REQ-015 IR_VALID  output  1  IR holds an instruction awaiting execution.
REQ-016 PC  output  32  current program counter.

Function
REQ-017 FSM states SHALL be FETCH and EXEC only.
REQ-018 FETCH, STALL=0: drive ADDR=PC, OE=1; at the rising edge ending the cycle, IR <= D[31:0], IR_VALID <= 1, go EXEC (1-cycle fetch latency; memory reads complete on the falling edge mid-cycle).
REQ-019 FETCH, STALL=1: ADDR=PC and OE=1 still driven; IR, PC, state unchanged.
REQ-020 EXEC: ADDR high-Z, OE=0, IR and IR_VALID held until EX_DONE=1.
REQ-021 EXEC with EX_DONE=1: PC <= PC_in if branch taken, else PC <= PC + PC_STEP; IR_VALID <= 0; go FETCH.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-023 EX_DONE or PC_LOAD in FETCH SHALL be ignored; STALL in EXEC SHALL be ignored.
REQ-024 PC_LOAD without EX_DONE SHALL have no effect.

Reset
REQ-025 rst=0 SHALL immediately force: PC=RESET_VECTOR, IR=0, IR_VALID=0, state=FETCH, OE=0, ADDR high-Z, regardless of clock or state.
REQ-026 First FETCH SHALL begin on the first rising edge after rst deasserts; reset mid-EXEC discards the pending instruction.

Configuration
REQ-027 Macro BRANCH_COND_EN defined: branch taken = PC_LOAD AND cond(BR_COND, Status); codes 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 V, 111 never.
REQ-028 Macro BRANCH_COND_EN undefined: branch taken = PC_LOAD; BR_COND and Status are ignored (ports remain).

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, BR_COND code constants and Status bit indices (V=3, C=2, N=1, Z=0).
REQ-030 Condition evaluation SHALL be a sub-module branch_cond_eval (combinational, BR_COND + Status -> taken), instantiated only under BRANCH_COND_EN.

Verification
REQ-031 Reset with RESET_VECTOR=32'h100 -> PC=0x100, IR_VALID=0, ADDR=Z; first cycle after release: ADDR=0x100, OE=1.
REQ-032 D[31:0]=0x8B02_0020 during FETCH at PC=0 -> next cycle IR=0x8B02_0020, IR_VALID=1, ADDR=Z; after EX_DONE, PC=4.
REQ-033 STALL=1 for 3 cycles in FETCH at PC=8 -> ADDR=8 all 3 cycles, IR unchanged; fetch completes the cycle STALL drops.
REQ-034 EXEC, EX_DONE=1, PC_LOAD=1, PC_in=0x40, BR_COND=001, Z=0 -> with BRANCH_COND_EN PC=PC+4; without, PC=0x40.
REQ-035 PC=0xFFFF_FFFC, EX_DONE=1, PC_LOAD=0 -> PC=0x0000_0000.
REQ-036 rst asserted mid-EXEC with IR_VALID=1 -> IR_VALID=0, PC=RESET_VECTOR at once, no clock edge required.
